// File: rtl/infix_converter.sv
// Infix-to-postfix token converter (shunting-yard) feeding a postfix calculator.
// Numbers pass straight through; operators are reordered through an internal
// operator stack so the downstream sees postfix order ending with '='.
module infix_converter #(
  parameter int OP_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_stb,
  input  logic [31:0] in_data,
  input  logic        in_is_operator,
  output logic        in_ack,
  output logic        out_stb,
  output logic [31:0] out_data,
  output logic        out_is_operator,
  input  logic        out_ack,
  output logic        err
);

  localparam int AW = (OP_DEPTH > 1) ? $clog2(OP_DEPTH) : 1;
  localparam int CW = $clog2(OP_DEPTH + 1);

  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_EQ  = 3'b100;
  localparam logic [2:0] OP_LP  = 3'b101;
  localparam logic [2:0] OP_RP  = 3'b110;

  typedef enum logic [2:0] {IDLE, EMIT, POP_CMP, PUSH, ACK, DONE, ERR} state_t;

  state_t        state, state_n;
  logic [2:0]    stack [OP_DEPTH];
  logic [CW-1:0] count;
  logic [AW-1:0] top_idx;
  logic [2:0]    top_op;
  logic [2:0]    cur_op;
  logic          ret_ack;
  logic          err_q;
  logic          err_ack;
  logic          err_gap;

  logic          do_push, do_pop, fault, latch_op, load_emit, emit_last;
  logic [31:0]   emit_word;
  logic          emit_op;

  // '(' gets precedence 0 so it never wins a comparison; it is excluded explicitly anyway.
  function automatic logic [1:0] prec(input logic [2:0] op);
    case (op)
      OP_MUL:         prec = 2'd2;
      OP_ADD, OP_SUB: prec = 2'd1;
      default:        prec = 2'd0;
    endcase
  endfunction

  assign top_idx = AW'(count - CW'(1));
  assign top_op  = stack[top_idx];

  assign out_stb = (state == EMIT);
  assign in_ack  = (state == ACK) || ((state == ERR) && err_ack);
  assign err     = err_q;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and datapath control: decides what to emit, push or pop each cycle.
  always_comb begin
    state_n   = state;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    fault     = 1'b0;
    latch_op  = 1'b0;
    load_emit = 1'b0;
    emit_last = 1'b0;
    emit_word = '0;
    emit_op   = 1'b0;
    case (state)
      IDLE: begin
        if (in_stb) begin
          if (!in_is_operator) begin
            load_emit = 1'b1;
            emit_word = in_data;
            emit_last = 1'b1;
            state_n   = EMIT;
          end else if (in_data[2:0] == 3'b000 || in_data[2:0] == 3'b111) begin
            fault   = 1'b1;
            state_n = ERR;
          end else begin
            latch_op = 1'b1;
            state_n  = POP_CMP;
          end
        end
      end
      POP_CMP: begin
        case (cur_op)
          OP_MUL, OP_ADD, OP_SUB: begin
            if (count != '0 && top_op != OP_LP && prec(top_op) >= prec(cur_op)) begin
              load_emit = 1'b1;
              emit_word = {29'b0, top_op};
              emit_op   = 1'b1;
              do_pop    = 1'b1;
              state_n   = EMIT;
            end else begin
              state_n = PUSH;
            end
          end
          OP_LP: state_n = PUSH;
          OP_RP: begin
            if (count == '0) begin
              fault   = 1'b1;
              state_n = ERR;
            end else if (top_op == OP_LP) begin
              do_pop  = 1'b1;
              state_n = ACK;
            end else begin
              load_emit = 1'b1;
              emit_word = {29'b0, top_op};
              emit_op   = 1'b1;
              do_pop    = 1'b1;
              state_n   = EMIT;
            end
          end
          OP_EQ: begin
            if (count == '0) begin
              load_emit = 1'b1;
              emit_word = {29'b0, OP_EQ};
              emit_op   = 1'b1;
              emit_last = 1'b1;
              state_n   = EMIT;
            end else if (top_op == OP_LP) begin
              fault   = 1'b1;
              state_n = ERR;
            end else begin
              load_emit = 1'b1;
              emit_word = {29'b0, top_op};
              emit_op   = 1'b1;
              do_pop    = 1'b1;
              state_n   = EMIT;
            end
          end
          default: begin
            fault   = 1'b1;
            state_n = ERR;
          end
        endcase
      end
      PUSH: begin
        if (count == CW'(OP_DEPTH)) begin
          fault   = 1'b1;
          state_n = ERR;
        end else begin
          do_push = 1'b1;
          state_n = ACK;
        end
      end
      EMIT: begin
        if (out_ack) state_n = ret_ack ? ACK : POP_CMP;
      end
      ACK:     state_n = DONE;
      DONE:    state_n = IDLE;
      ERR:     state_n = ERR;
      default: state_n = IDLE;
    endcase
  end

  // Stack count, emission registers and the sticky error / drop-ack bookkeeping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count           <= '0;
      out_data        <= '0;
      out_is_operator <= 1'b0;
      cur_op          <= 3'b000;
      ret_ack         <= 1'b0;
      err_q           <= 1'b0;
      err_ack         <= 1'b0;
      err_gap         <= 1'b0;
    end else begin
      if (load_emit) begin
        out_data        <= emit_word;
        out_is_operator <= emit_op;
        ret_ack         <= emit_last;
      end
      if (latch_op) cur_op <= in_data[2:0];
      if (fault) begin
        count   <= '0;
        err_q   <= 1'b1;
        err_ack <= 1'b1;
        err_gap <= 1'b0;
      end else begin
        if (do_push)     count <= count + CW'(1);
        else if (do_pop) count <= count - CW'(1);
        if (state == ERR) begin
          err_ack <= in_stb && !err_ack && !err_gap;
          err_gap <= err_ack;
        end
      end
    end
  end

  // Operator stack storage; contents are don't-care beyond the current count.
  always_ff @(posedge CLK) begin
    if (do_push) stack[AW'(count)] <= cur_op;
  end

endmodule

// File: tb/tb_infix_converter.sv
// Self-checking bench for infix_converter: directed scenarios plus random
// well-formed expressions compared against a queue-based shunting-yard model.
module tb_infix_converter;

  typedef logic [32:0] tok_t;
  typedef tok_t tokq_t[$];

  localparam logic [2:0] MUL = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] SUB = 3'd3;
  localparam logic [2:0] EQ  = 3'd4;
  localparam logic [2:0] LP  = 3'd5;
  localparam logic [2:0] RP  = 3'd6;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_stb;
  logic [31:0] in_data;
  logic        in_is_operator;
  logic        in_ack;
  logic        out_stb;
  logic [31:0] out_data;
  logic        out_is_operator;
  logic        out_ack;
  logic        err;

  int    checks = 0;
  int    passes = 0;
  tok_t  got_q[$];

  infix_converter #(.OP_DEPTH(16)) dut (
    .CLK(CLK), .RST(RST),
    .in_stb(in_stb), .in_data(in_data), .in_is_operator(in_is_operator), .in_ack(in_ack),
    .out_stb(out_stb), .out_data(out_data), .out_is_operator(out_is_operator), .out_ack(out_ack),
    .err(err)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  // Watchdog so the run always terminates.
  initial begin
    #800000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic tok_t num(input int unsigned v);
    return {1'b0, 32'(v)};
  endfunction

  function automatic tok_t opt(input logic [2:0] c);
    return {1'b1, 29'b0, c};
  endfunction

  function automatic int prec(input logic [2:0] c);
    return (c == MUL) ? 2 : 1;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: textbook shunting-yard over queues.
  task automatic model(input tokq_t expr, output tokq_t res);
    tok_t st[$];
    tok_t top;
    res = {};
    foreach (expr[i]) begin
      if (!expr[i][32]) res.push_back(expr[i]);
      else begin
        case (expr[i][2:0])
          MUL, ADD, SUB: begin
            while (st.size() > 0) begin
              top = st[$];
              if (top[2:0] == LP || prec(top[2:0]) < prec(expr[i][2:0])) break;
              res.push_back(top);
              void'(st.pop_back());
            end
            st.push_back(expr[i]);
          end
          LP: st.push_back(expr[i]);
          RP: begin
            while (st.size() > 0) begin
              top = st.pop_back();
              if (top[2:0] == LP) break;
              res.push_back(top);
            end
          end
          default: begin
            while (st.size() > 0) res.push_back(st.pop_back());
            res.push_back(expr[i]);
          end
        endcase
      end
    end
  endtask

  // Postfix calculator applied to what the DUT emitted.
  task automatic eval_postfix(output int unsigned result);
    int unsigned vs[$];
    int unsigned a, b;
    tok_t t;
    result = 0;
    foreach (got_q[i]) begin
      t = got_q[i];
      if (!t[32]) vs.push_back(t[31:0]);
      else if (t[2:0] == EQ) begin
        if (vs.size() > 0) result = vs[$];
      end else if (vs.size() >= 2) begin
        b = vs.pop_back();
        a = vs.pop_back();
        case (t[2:0])
          MUL:     vs.push_back(a * b);
          ADD:     vs.push_back(a + b);
          default: vs.push_back(a - b);
        endcase
      end
    end
  endtask

  // Present one token, acknowledge emissions at random, collect accepted outputs.
  task automatic apply_stimulus(input tok_t t, input int ack_pct);
    int       cycles;
    bit       got, prev_acc, prev_stb;
    tok_t     prev_word;
    in_stb = 1'b1;
    in_is_operator = t[32];
    in_data = t[31:0];
    got = 0; cycles = 0; prev_acc = 0; prev_stb = 0; prev_word = '0;
    while (!got && cycles < 400) begin
      @(posedge CLK); #1;
      cycles++;
      if (prev_acc) check_output("gap_after_accept", out_stb, 1'b0);
      else if (prev_stb && out_stb) check_output("hold_stable", {out_is_operator, out_data}, prev_word);
      prev_acc = 0;
      if (in_ack) begin
        got = 1;
        out_ack = 1'b0;
      end else if (out_stb) begin
        out_ack = ($urandom_range(99) < ack_pct);
        if (out_ack) begin
          got_q.push_back({out_is_operator, out_data});
          prev_acc = 1;
        end
      end else begin
        out_ack = 1'b0;
      end
      prev_stb = out_stb;
      prev_word = {out_is_operator, out_data};
    end
    check_output("in_ack_seen", got, 1'b1);
    @(posedge CLK); #1;
    check_output("in_ack_pulse", in_ack, 1'b0);
    in_stb = 1'b0;
    out_ack = 1'b0;
  endtask

  task automatic run_expr(input tokq_t expr, input int ack_pct, input string tag);
    tokq_t exp;
    got_q.delete();
    foreach (expr[i]) apply_stimulus(expr[i], ack_pct);
    model(expr, exp);
    check_output({tag, "_len"}, got_q.size(), exp.size());
    foreach (exp[i]) if (i < got_q.size()) check_output({tag, "_tok"}, got_q[i], exp[i]);
    check_output({tag, "_err"}, err, 1'b0);
  endtask

  task automatic gen_expr(output tokq_t e);
    int depth = 0;
    int terms = $urandom_range(1, 7);
    e = {};
    for (int k = 0; k < terms; k++) begin
      while (depth < 4 && $urandom_range(3) == 0) begin
        e.push_back(opt(LP));
        depth++;
      end
      e.push_back(num($urandom));
      while (depth > 0 && $urandom_range(2) == 0) begin
        e.push_back(opt(RP));
        depth--;
      end
      if (k < terms - 1) e.push_back(opt(3'($urandom_range(1, 3))));
    end
    while (depth > 0) begin
      e.push_back(opt(RP));
      depth--;
    end
    e.push_back(opt(EQ));
  endtask

  task automatic do_reset();
    in_stb = 1'b0;
    out_ack = 1'b0;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Directed scenarios followed by randomized expressions.
  initial begin
    tokq_t       e;
    int unsigned v;
    in_stb = 1'b0; in_data = '0; in_is_operator = 1'b0; out_ack = 1'b0; RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_output("rst_outputs", {out_stb, out_data, out_is_operator, in_ack, err}, 36'h0);
    RST = 1'b0;

    // Latency with out_ack high, plus DONE ignoring a held in_stb.
    @(posedge CLK); #1;
    in_stb = 1'b1; in_is_operator = 1'b0; in_data = 32'd42; out_ack = 1'b1;
    @(posedge CLK); #1;
    check_output("lat_t1", {in_ack, out_stb, out_is_operator, out_data}, {3'b010, 32'd42});
    @(posedge CLK); #1;
    check_output("lat_t2", {in_ack, out_stb}, 2'b10);
    @(posedge CLK); #1;
    check_output("lat_t3", {in_ack, out_stb}, 2'b00);
    in_data = 32'd77;
    @(posedge CLK); #1;
    check_output("lat_t4", out_stb, 1'b0);
    @(posedge CLK); #1;
    check_output("lat_t5", {out_stb, out_data}, {1'b1, 32'd77});
    @(posedge CLK); #1;
    check_output("lat_t6", in_ack, 1'b1);
    @(posedge CLK); #1;
    in_stb = 1'b0; out_ack = 1'b0;

    e = {num(3), opt(ADD), num(4), opt(MUL), num(5), opt(EQ)};
    run_expr(e, 100, "prec");
    eval_postfix(v);
    check_output("prec_value", v, 23);

    e = {opt(LP), num(3), opt(ADD), num(4), opt(RP), opt(MUL), num(5), opt(EQ)};
    run_expr(e, 60, "paren");
    eval_postfix(v);
    check_output("paren_value", v, 35);

    e = {num(10), opt(SUB), num(4), opt(SUB), num(3), opt(EQ)};
    run_expr(e, 100, "assoc");
    eval_postfix(v);
    check_output("assoc_value", v, 3);

    // Back-pressure: out_ack held low for ten cycles on a number.
    @(posedge CLK); #1;
    in_stb = 1'b1; in_is_operator = 1'b0; in_data = 32'd9; out_ack = 1'b0;
    @(posedge CLK); #1;
    for (int c = 0; c < 10; c++) begin
      check_output("bp_hold", {in_ack, out_stb, out_data}, {2'b01, 32'd9});
      @(posedge CLK); #1;
    end
    out_ack = 1'b1;
    check_output("bp_still", {in_ack, out_stb}, 2'b01);
    @(posedge CLK); #1;
    out_ack = 1'b0;
    check_output("bp_ack", {in_ack, out_stb}, 2'b10);
    @(posedge CLK); #1;
    in_stb = 1'b0;
    @(posedge CLK); #1;

    // Reset in the middle of a pending emission, with a '(' left on the stack.
    got_q.delete();
    apply_stimulus(opt(LP), 100);
    in_stb = 1'b1; in_is_operator = 1'b0; in_data = 32'd8; out_ack = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    check_output("midrst_out", {in_ack, out_stb, err}, 3'b000);
    RST = 1'b0; in_stb = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      check_output("midrst_noack", {in_ack, out_stb}, 2'b00);
    end
    e = {num(1), opt(ADD), num(2), opt(EQ)};
    run_expr(e, 100, "after_rst");
    eval_postfix(v);
    check_output("after_rst_value", v, 3);

    // ')' first: sticky error, later tokens dropped.
    do_reset();
    got_q.delete();
    apply_stimulus(opt(RP), 100);
    check_output("rp_err", err, 1'b1);
    for (int k = 0; k < 7; k++) apply_stimulus(opt(EQ), 100);
    check_output("rp_no_out", got_q.size(), 0);
    check_output("rp_err_sticky", err, 1'b1);

    // Illegal codes and an unmatched '(' at '='.
    do_reset();
    apply_stimulus(opt(3'd0), 100);
    check_output("code0_err", err, 1'b1);
    do_reset();
    apply_stimulus(opt(3'd7), 100);
    check_output("code7_err", err, 1'b1);
    do_reset();
    got_q.delete();
    apply_stimulus(opt(LP), 100);
    apply_stimulus(num(1), 100);
    apply_stimulus(opt(EQ), 100);
    check_output("open_eq_err", err, 1'b1);
    check_output("open_eq_out", got_q.size(), 1);

    // Stack overflow on the seventeenth '('.
    do_reset();
    for (int k = 0; k < 16; k++) apply_stimulus(opt(LP), 100);
    check_output("ovf_16_ok", err, 1'b0);
    apply_stimulus(opt(LP), 100);
    check_output("ovf_17_err", err, 1'b1);
    do_reset();
    e = {num(2), opt(ADD), num(2), opt(EQ)};
    run_expr(e, 100, "post_ovf");
    eval_postfix(v);
    check_output("post_ovf_value", v, 4);

    // Random well-formed expressions with random downstream stalls.
    for (int n = 0; n < 25; n++) begin
      gen_expr(e);
      run_expr(e, $urandom_range(20, 100), "rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
